// File: rtl/rc_pkt_store_pkg.sv
// Shared PCIe RC-interface definitions: bus widths, tuser field positions and
// the completion store FSM encoding.
package rc_pkt_store_pkg;

  localparam int RC_DATA_W   = 256;
  localparam int RC_KEEP_W   = 8;
  localparam int RC_TUSER_W  = 75;
  localparam int RC_DISC_BIT = 42;
  localparam int RC_ASIZE    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } state_t;

endpackage

// File: rtl/rc_pkt_store_if.sv
// AXI-Stream RC completion bus (valid/ready, last, data, dword keep, tuser).
interface rc_pkt_store_if
  import rc_pkt_store_pkg::*;
#(
  parameter int DATA_W = RC_DATA_W,
  parameter int KEEP_W = RC_KEEP_W
);

  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_W-1:0]     tdata;
  logic [KEEP_W-1:0]     tkeep;
  logic [RC_TUSER_W-1:0] tuser;

  modport master (output tvalid, tlast, tdata, tkeep, tuser, input tready);
  modport slave  (input tvalid, tlast, tdata, tkeep, tuser, output tready);

endinterface

// File: rtl/rc_pkt_store.sv
// Store-and-forward buffer for RC completions; discontinued or oversize TLPs are dropped whole.
// Latency: first beat visible the cycle after its tlast is accepted; reads add no latency.
// Backpressure: s_tready low only when full (never while dropping); m side is plain valid/ready.
module rc_pkt_store
  import rc_pkt_store_pkg::*;
#(
  parameter int DATA_W = RC_DATA_W,
  parameter int KEEP_W = RC_KEEP_W,
  parameter int ASIZE  = RC_ASIZE
) (
  input  logic           pcie_clk,
  input  logic           pcie_rst,
  rc_pkt_store_if.slave  s_axis_rc,
  rc_pkt_store_if.master m_axis_rc,
  output logic [15:0]    drop_cnt
);

  localparam int DEPTH = 1 << ASIZE;
  localparam int ENT_W = 1 + KEEP_W + DATA_W;

  typedef logic [ASIZE:0] ptr_t;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] rd_ent;

  ptr_t   wr_ptr, cmt_ptr, rd_ptr;
  ptr_t   wr_nxt, cmt_nxt;
  state_t state, state_nxt;
  logic   full, disc, s_acc, m_vld, m_acc, drop_inc, mem_wr;

  assign full  = (wr_ptr[ASIZE] != rd_ptr[ASIZE]) &&
                 (wr_ptr[ASIZE-1:0] == rd_ptr[ASIZE-1:0]);
  assign disc  = s_axis_rc.tuser[RC_DISC_BIT];

  assign s_axis_rc.tready = !pcie_rst && ((state == ST_DROP) || !full);
  assign s_acc = s_axis_rc.tvalid && s_axis_rc.tready;

  // Only committed beats are exposed, so a TLP is never forwarded partially.
  assign m_vld  = !pcie_rst && (rd_ptr != cmt_ptr);
  assign m_acc  = m_vld && m_axis_rc.tready;
  assign rd_ent = mem[rd_ptr[ASIZE-1:0]];

  assign m_axis_rc.tvalid = m_vld;
  assign {m_axis_rc.tlast, m_axis_rc.tkeep, m_axis_rc.tdata} = m_vld ? rd_ent : '0;
  assign m_axis_rc.tuser  = '0;

  always_comb begin
    state_nxt = state;
    wr_nxt    = wr_ptr;
    cmt_nxt   = cmt_ptr;
    drop_inc  = 1'b0;
    mem_wr    = 1'b0;
    case (state)
      ST_IDLE, ST_RECV: begin
        if (s_acc) begin
          mem_wr = 1'b1;
          if (disc) begin
            wr_nxt = cmt_ptr;
            if (s_axis_rc.tlast) begin
              drop_inc  = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_DROP;
            end
          end else begin
            wr_nxt = wr_ptr + 1'b1;
            if (s_axis_rc.tlast) begin
              cmt_nxt   = wr_ptr + 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_RECV;
            end
          end
        end else if (state == ST_RECV && full && cmt_ptr == rd_ptr) begin
          // TLP larger than the whole buffer: nothing can drain, so give it up.
          wr_nxt    = cmt_ptr;
          state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (s_acc && s_axis_rc.tlast) begin
          drop_inc  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      cmt_ptr  <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      state   <= state_nxt;
      wr_ptr  <= wr_nxt;
      cmt_ptr <= cmt_nxt;
      if (m_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (drop_inc && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge pcie_clk) begin
    if (mem_wr) begin
      mem[wr_ptr[ASIZE-1:0]] <= {s_axis_rc.tlast, s_axis_rc.tkeep, s_axis_rc.tdata};
    end
  end

endmodule
